// File: rtl/dmem_pkg.sv
// +------------------------------------------------------------------+
// | dmem_pkg: shared types for the data-memory responder             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +------------------------------------------------------------------+
// | dmem_array: DEPTH x 64 single-port array, sync write / sync read |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);

  logic [63:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) r_mem[idx] <= wdata;
      else    rdata      <= r_mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +------------------------------------------------------------------+
// | data_mem_responder: valid/ready data-memory responder with fixed |
// | wait states. Optional address checking: DMEM_ERR_CHECK_EN.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(WAIT_CYCLES);

  state_t           r_state;
  req_t             r_req;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_load_ok;

  req_t             w_in_req;
  req_t             w_acc_req;
  logic             w_accept;
  logic             w_access;
  logic             w_bad;
  logic             w_arr_en;
  logic [63:0]      w_arr_rdata;

  assign w_in_req = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign w_accept = (r_state == ST_IDLE) && req_valid && r_req_ready;
  assign w_access = (WAIT_CYCLES == 0) ? w_accept
                                       : ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));

  // With zero wait states the access uses the live request on the acceptance edge.
  always_comb begin
    w_acc_req = r_req;
    if (WAIT_CYCLES == 0) w_acc_req = w_in_req;
  end

`ifdef DMEM_ERR_CHECK_EN
  assign w_bad = (w_acc_req.addr[2:0] != 3'd0) || (w_acc_req.addr[63:IDX_W+3] != '0);
`else
  logic w_unused;
  assign w_bad    = 1'b0;
  assign w_unused = ^{w_acc_req.addr[63:IDX_W+3], w_acc_req.addr[2:0]};
`endif

  assign w_arr_en = w_access && !w_bad;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (w_arr_en),
    .we    (w_acc_req.we),
    .idx   (w_acc_req.addr[IDX_W+2:3]),
    .wdata (w_acc_req.wdata),
    .rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_load_ok   <= 1'b0;
    end else begin
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_bad;
        r_load_ok   <= !w_acc_req.we && !w_bad;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req       <= w_in_req;
            r_cnt       <= C_WAIT;
            r_req_ready <= 1'b0;
            r_state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Array read data is held by the array while no access occurs, so it stays stable in RESP.
  assign rsp_rdata = r_load_ok ? w_arr_rdata : 64'd0;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// +------------------------------------------------------------------+
// | tb_data_mem_responder: directed bench, WAIT_CYCLES=2 and 0 DUTs  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [63:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata;
  logic        a_req_valid, b_req_valid;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;
  longint last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign a_req_valid = req_valid && !sel;
  assign b_req_valid = req_valid && sel;
  assign req_ready   = sel ? b_req_ready : a_req_ready;
  assign rsp_valid   = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err     = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata   = sel ? b_rsp_rdata : a_rsp_rdata;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [63:0] addr);
`ifdef DMEM_ERR_CHECK_EN
    return (addr[2:0] != 3'd0) || (addr >= 64'(DEPTH * 8));
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction, entered and left at a negedge. hold > 0 keeps rsp_ready
  // low that many cycles while a competing store is offered; exp_gap > 0 checks spacing.
  task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input int wc, input logic [63:0] exp_rdata,
                      input int hold, input int exp_gap);
    int     k;
    int     lat;
    longint acc;
    logic [63:0] held;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    if (hold > 0) rsp_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "/accept_timeout"}, 64'(k < 20), 64'd1);
    @(posedge clk); #1;
    acc = cyc;
    if (exp_gap > 0) check({tag, "/req_gap"}, 64'(acc - last_acc), 64'(exp_gap));
    last_acc = acc;
    @(negedge clk);
    lat = 1;
    req_valid = 1'b0;
    check({tag, "/busy_ready"}, 64'(req_ready), 64'd0);
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    check({tag, "/latency"}, 64'(lat), 64'(wc + 1));
    check({tag, "/rdata"}, rsp_rdata, exp_rdata);
    check({tag, "/err"}, 64'(rsp_err), 64'(exp_err(addr)));
    if (hold > 0) begin
      held = rsp_rdata;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h1F8; req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
      repeat (hold) begin
        @(negedge clk);
        check({tag, "/bp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "/bp_rdata"}, rsp_rdata, held);
        check({tag, "/bp_ready"}, 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "/rsp_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] v_dead, v_a, v_one, v_two, v_old;
    logic        mac;
    v_dead = 64'hDEAD_BEEF_0123_4567;
    v_a    = 64'hAAAA_5555_AAAA_5555;
    v_one  = 64'h1111_1111_1111_1111;
    v_two  = 64'h2222_2222_2222_2222;
    v_old  = 64'h0000_0000_0000_1234;
`ifdef DMEM_ERR_CHECK_EN
    mac = 1'b1;
`else
    mac = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("rst/req_ready", 64'(req_ready), 64'd0);
    check("rst/rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst/rsp_rdata", rsp_rdata, 64'd0);
    check("rst/rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel/req_ready", 64'(req_ready), 64'd1);

    // WAIT_CYCLES = 2 instance
    sel = 1'b0;
    xact("st10", 1'b1, 64'h10, v_dead, 2, 64'd0, 0, 0);
    xact("ld10", 1'b0, 64'h10, 64'd0, 2, v_dead, 0, 4);
    xact("st1f8", 1'b1, 64'h1F8, v_a, 2, 64'd0, 0, 0);
    xact("st08", 1'b1, 64'h8, v_one, 2, 64'd0, 0, 0);
    xact("bp_ld10", 1'b0, 64'h10, 64'd0, 2, v_dead, 5, 0);
    xact("ld1f8", 1'b0, 64'h1F8, 64'd0, 2, v_a, 0, 0);
    xact("st808", 1'b1, 64'h808, v_two, 2, 64'd0, 0, 0);
    xact("ld08", 1'b0, 64'h8, 64'd0, 2, mac ? v_one : v_two, 0, 0);
    xact("ld13", 1'b0, 64'h13, 64'd0, 2, mac ? 64'd0 : v_dead, 0, 0);

    // Reset while a store is still waiting
    xact("st20", 1'b1, 64'h20, v_old, 2, 64'd0, 0, 0);
    req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'h55; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst/rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst/req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst/rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_rst/req_ready", 64'(req_ready), 64'd1);
    xact("ld20", 1'b0, 64'h20, 64'd0, 2, v_old, 0, 0);

    // WAIT_CYCLES = 0 instance, back-to-back
    sel = 1'b1;
    xact("w0_st40", 1'b1, 64'h40, v_one, 0, 64'd0, 0, 0);
    xact("w0_st48", 1'b1, 64'h48, v_a, 0, 64'd0, 0, 2);
    xact("w0_ld40", 1'b0, 64'h40, 64'd0, 0, v_one, 0, 2);
    xact("w0_ld48", 1'b0, 64'h48, 64'd0, 0, v_a, 0, 2);
    xact("w0_ld40b", 1'b0, 64'h40, 64'd0, 0, v_one, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
